// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encoding and default operand width
// common to the multiplier and divider blocks.
package arith_pkg;

    // Default operand width for the arithmetic blocks.
    localparam int ARITH_WIDTH = 8;

    // Control states shared by the iterative arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } arith_state_e;

    // Bits needed for a step counter that runs 0..w.
    function automatic int arith_cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/booth_mul_if.sv
// Handshake/data bundle for the Booth multiplier.
// master: requester driving start/X/Y; slave: the multiplier.
interface booth_mul_if
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) ();

    logic                   start;
    logic [WIDTH-1:0]       X;
    logic [WIDTH-1:0]       Y;
    logic                   busy;
    logic                   data_ok;
    logic [2*WIDTH-1:0]     P;

    modport master (
        output start, X, Y,
        input  busy, data_ok, P
    );

    modport slave (
        input  start, X, Y,
        output busy, data_ok, P
    );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the sign-extended
// multiplicand into A, then arithmetic right shift of {A,Q,q_1}.
// A is WIDTH+1 bits so subtracting the most negative multiplicand cannot overflow.
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q1_in,
    input  logic [WIDTH-1:0] xl,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q1_out
);

    logic [WIDTH:0] x_sext;
    logic [WIDTH:0] sum;

    assign x_sext = {xl[WIDTH-1], xl};

    // Booth recoding of {Q[0], q_1}: 01 adds, 10 subtracts, 00/11 pass through.
    always_comb begin
        sum = a_in;
        case ({q_in[0], q1_in})
            2'b01:   sum = a_in + x_sext;
            2'b10:   sum = a_in - x_sext;
            default: sum = a_in;
        endcase
    end

    assign a_out  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_out  = {sum[0], q_in[WIDTH-1:1]};
    assign q1_out = q_in[0];

endmodule

// File: rtl/booth_mul.sv
// Sequential radix-2 Booth multiplier, one step per clock.
// start in IDLE/DONE latches X/Y and enters CALC; after WIDTH steps the
// product is written to P and held in DONE with data_ok until the next start.
// Optional build macro BOOTH_MUL_ZERO_SKIP_EN: a zero operand finishes after
// a single CALC cycle with P=0.
module booth_mul
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    booth_mul_if.slave bus
);

    localparam int CW = arith_cnt_bits(WIDTH);

    arith_state_e         state_reg, state_next;
    logic [WIDTH:0]       a_reg, a_next;
    logic [WIDTH-1:0]     q_reg, q_next;
    logic                 q1_reg, q1_next;
    logic [WIDTH-1:0]     xl_reg, xl_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [2*WIDTH-1:0]   p_reg, p_next;

    logic [WIDTH:0]       a_step;
    logic [WIDTH-1:0]     q_step;
    logic                 q1_step;
    logic                 last_step;
    logic                 zero_skip;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_in   (a_reg),
        .q_in   (q_reg),
        .q1_in  (q1_reg),
        .xl     (xl_reg),
        .a_out  (a_step),
        .q_out  (q_step),
        .q1_out (q1_step)
    );

    // Step count is 0-based, so the WIDTH-th step runs while count is WIDTH-1.
    assign last_step = (count_reg == CW'(WIDTH - 1));

`ifdef BOOTH_MUL_ZERO_SKIP_EN
    // On the first CALC cycle Q still holds the latched Y.
    assign zero_skip = (count_reg == '0) && ((xl_reg == '0) || (q_reg == '0));
`else
    assign zero_skip = 1'b0;
`endif

    // State and datapath registers; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            q1_reg    <= 1'b0;
            xl_reg    <= '0;
            count_reg <= '0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            q_reg     <= q_next;
            q1_reg    <= q1_next;
            xl_reg    <= xl_next;
            count_reg <= count_next;
            p_reg     <= p_next;
        end
    end

    // Next-state and datapath update; P only changes on entry to DONE.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        q_next     = q_reg;
        q1_next    = q1_reg;
        xl_next    = xl_reg;
        count_next = count_reg;
        p_next     = p_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = CALC;
                    a_next     = '0;
                    q_next     = bus.Y;
                    q1_next    = 1'b0;
                    xl_next    = bus.X;
                    count_next = '0;
                end
            end
            CALC: begin
                if (zero_skip) begin
                    state_next = DONE;
                    p_next     = '0;
                end else begin
                    a_next     = a_step;
                    q_next     = q_step;
                    q1_next    = q1_step;
                    count_next = count_reg + CW'(1);
                    if (last_step) begin
                        state_next = DONE;
                        p_next     = {a_step[WIDTH-1:0], q_step};
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg == CALC);
    assign bus.data_ok = (state_reg == DONE);
    assign bus.P       = p_reg;

endmodule

// File: tb/tb_booth_mul.sv
// Self-checking bench for booth_mul at WIDTH=8 and WIDTH=5.
// Expected products are queued when a multiply is launched and popped when
// data_ok rises; latency, busy length and P stability are checked per run.
module tb_booth_mul;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth_mul_if #(.WIDTH(8)) if8 ();
    booth_mul_if #(.WIDTH(5)) if5 ();

    booth_mul #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    booth_mul #(.WIDTH(5)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] exp8_q[$];
    logic [9:0]  exp5_q[$];
    logic        ok8_prev = 1'b0;
    logic        ok5_prev = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input int w, input bit has_zero);
`ifdef BOOTH_MUL_ZERO_SKIP_EN
        return has_zero ? 1 : w;
`else
        return (has_zero && 1'b0) ? 1 : w;
`endif
    endfunction

    // Scoreboard for the 8-bit instance: compare on every rising data_ok.
    always @(negedge clk) begin
        logic [15:0] e;
        if (if8.data_ok && !ok8_prev) begin
            if (exp8_q.size() == 0) begin
                check_val("w8_pending", 64'(exp8_q.size()), 64'd1);
            end else begin
                e = exp8_q.pop_front();
                $display("txn w8: P=%h expected=%h", if8.P, e);
                check_val("w8_P", 64'(if8.P), 64'(e));
            end
        end
        ok8_prev <= if8.data_ok;
    end

    // Scoreboard for the 5-bit instance.
    always @(negedge clk) begin
        logic [9:0] e;
        if (if5.data_ok && !ok5_prev) begin
            if (exp5_q.size() == 0) begin
                check_val("w5_pending", 64'(exp5_q.size()), 64'd1);
            end else begin
                e = exp5_q.pop_front();
                $display("txn w5: P=%h expected=%h", if5.P, e);
                check_val("w5_P", 64'(if5.P), 64'(e));
            end
        end
        ok5_prev <= if5.data_ok;
    end

    task automatic run8(input logic [7:0] x, input logic [7:0] y, input string tag);
        logic [15:0] p_before;
        int          n;
        int          busy_n;
        bit          p_held;
        int          lat;
        lat = exp_lat(8, (x == 0) || (y == 0));
        @(negedge clk);
        if8.X     = x;
        if8.Y     = y;
        if8.start = 1'b1;
        exp8_q.push_back(16'(longint'($signed(x)) * longint'($signed(y))));
        p_before = if8.P;
        @(negedge clk);
        if8.start = 1'b0;
        n = 0; busy_n = 0; p_held = 1'b1;
        while (!if8.data_ok && n < 40) begin
            if (if8.busy) busy_n++;
            if (if8.P !== p_before) p_held = 1'b0;
            @(negedge clk);
            n++;
        end
        check_val({tag, "_lat"}, 64'(n), 64'(lat));
        check_val({tag, "_busy"}, 64'(busy_n), 64'(lat));
        check_val({tag, "_hold"}, 64'(p_held), 64'd1);
    endtask

    task automatic run5(input logic [4:0] x, input logic [4:0] y);
        int n;
        @(negedge clk);
        if5.X     = x;
        if5.Y     = y;
        if5.start = 1'b1;
        exp5_q.push_back(10'(longint'($signed(x)) * longint'($signed(y))));
        @(negedge clk);
        if5.start = 1'b0;
        n = 0;
        while (!if5.data_ok && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("w5_lat", 64'(n), 64'(exp_lat(5, (x == 0) || (y == 0))));
    endtask

    initial begin
        int n;
        if8.start = 1'b0; if8.X = '0; if8.Y = '0;
        if5.start = 1'b0; if5.X = '0; if5.Y = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(if8.busy), 64'd0);
        check_val("rst_ok", 64'(if8.data_ok), 64'd0);
        check_val("rst_P", 64'(if8.P), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", 64'(if8.busy), 64'd0);
        check_val("idle_P5", 64'(if5.P), 64'd0);

        // Directed products, including the extreme operands.
        run8(8'hF8, 8'h03, "neg8x3");
        run8(8'h80, 8'h80, "min_min");
        run8(8'h7F, 8'h80, "max_min");
        run8(8'h00, 8'h37, "zero_x");
        run8(8'h37, 8'h00, "zero_y");
        run8(8'hFF, 8'hFF, "m1_m1");

        // start held high with X/Y wandering during CALC, then back-to-back.
        @(negedge clk);
        if8.X = 8'h5A; if8.Y = 8'hD3; if8.start = 1'b1;
        exp8_q.push_back(16'(longint'($signed(8'h5A)) * longint'($signed(8'hD3))));
        @(negedge clk);
        n = 0;
        while (!if8.data_ok && n < 40) begin
            if8.X = 8'($urandom);
            if8.Y = 8'($urandom);
            @(negedge clk);
            n++;
        end
        check_val("hold_lat", 64'(n), 64'd8);
        if8.X = 8'h81; if8.Y = 8'h7F;
        exp8_q.push_back(16'(longint'($signed(8'h81)) * longint'($signed(8'h7F))));
        @(negedge clk);
        check_val("b2b_ok_drop", 64'(if8.data_ok), 64'd0);
        check_val("b2b_busy", 64'(if8.busy), 64'd1);
        if8.start = 1'b0;
        n = 0;
        while (!if8.data_ok && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("b2b_lat", 64'(n), 64'd8);

        // Reset pulsed during CALC cycle 4.
        @(negedge clk);
        if8.X = 8'd100; if8.Y = 8'hB3; if8.start = 1'b1;
        exp8_q.push_back(16'(longint'($signed(8'd100)) * longint'($signed(8'hB3))));
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_busy", 64'(if8.busy), 64'd1);
        #2;
        rst_n = 1'b0;
        exp8_q.delete();
        exp5_q.delete();
        #1;
        check_val("arst_busy", 64'(if8.busy), 64'd0);
        check_val("arst_ok", 64'(if8.data_ok), 64'd0);
        check_val("arst_P", 64'(if8.P), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_idle", 64'(if8.busy), 64'd0);
        run8(8'd100, 8'hB3, "after_rst");

        // Randomized operands at both widths.
        for (int i = 0; i < 1000; i++) begin
            run8(8'($urandom), 8'($urandom), "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            run5(5'($urandom), 5'($urandom));
        end

        repeat (2) @(negedge clk);
        check_val("w8_drain", 64'(exp8_q.size()), 64'd0);
        check_val("w5_drain", 64'(exp5_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mul.md
BOOTH_MUL -- requirements
Module: booth_mul

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (>= 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 SHALL have port: X  input  WIDTH  signed multiplicand, two's complement.
REQ-006 SHALL have port: Y  input  WIDTH  signed multiplier, two's complement.
REQ-007 SHALL have port: busy  output  1  high while in CALC.
REQ-008 SHALL have port: data_ok  output  1  high while P holds a valid product.
REQ-009 SHALL have port: P  output  2*WIDTH  signed product X*Y, two's complement.

Function
REQ-010 SHALL implement states IDLE, CALC and DONE; reset state IDLE.
REQ-011 SHALL latch X and Y, then move IDLE->CALC, on the first edge with start=1 (edge 0).
- At that edge: accumulator A(WIDTH+1 bits) = 0, Q = Y, q_1 = 0, count = 0.
REQ-012 SHALL perform one radix-2 Booth step per CALC cycle, selected by {Q[0],q_1}:
- 01: A = A + sext(Xl).
- 10: A = A - sext(Xl).
- 00/11: no add.
- Then arithmetic-shift {A,Q,q_1} right by 1.
REQ-013 SHALL keep A at WIDTH+1 bits so that subtracting Xl = -2^(WIDTH-1) never overflows.
REQ-014 SHALL transition CALC->DONE on the edge completing step WIDTH (edge WIDTH after start).
- On that edge: P = {A[WIDTH-1:0],Q}, data_ok = 1, busy = 0.
REQ-015 SHALL hold P and data_ok=1 in DONE until start=1 is sampled.
- start=1 in DONE reloads operands and enters CALC; data_ok drops on that edge.
REQ-016 SHALL ignore start and changes on X/Y while in CALC; the latched operands are used.
REQ-017 SHALL keep P unchanged from the previous result while in IDLE and CALC; only DONE entry updates P.
REQ-018 SHALL assert busy exactly in CALC, and data_ok exactly in DONE.
REQ-019 SHALL produce the exact product for every operand pair, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2).

Reset
REQ-020 SHALL asynchronously force on rst_n=0: state=IDLE, busy=0, data_ok=0, P=0, A=0, Q=0, q_1=0, count=0.
REQ-021 SHALL abandon any in-flight multiply when reset asserts mid-CALC; no partial result appears on P.
REQ-022 SHALL resume on the first rising edge after rst_n deasserts, treating that edge as an IDLE edge.

Configuration
REQ-023 SHALL support macro BOOTH_MUL_ZERO_SKIP_EN.
- Defined: if the latched X or Y is zero, CALC->DONE occurs on the next edge (edge 1) with P=0.
- Not defined: every multiply takes WIDTH CALC cycles regardless of operand values.

Structure
REQ-024 SHALL import state enum (IDLE/CALC/DONE) and default WIDTH constant from shared package arith_pkg, also used by the divider blocks.
REQ-025 SHALL place one Booth step (A,Q,q_1,Xl in; shifted A,Q,q_1 out) in combinational sub-module booth_step.

Verification
REQ-026 SHALL cover: X=-8, Y=3, start 1 cycle -> busy 8 cycles, then data_ok=1, P=16'hFFE8 (-24).
REQ-027 SHALL cover: X=-128, Y=-128 -> P=16'h4000; X=127, Y=-128 -> P=16'hC080 (-16256).
REQ-028 SHALL cover: X=0, Y=55 -> P=0; latency 8 cycles without BOOTH_MUL_ZERO_SKIP_EN, 1 cycle with it.
REQ-029 SHALL cover: start held high and X/Y changed during CALC.
- First result is unaffected.
- Back-to-back start in DONE yields the second product after 8 more cycles.
REQ-030 SHALL cover: rst_n pulsed low at CALC cycle 4 -> outputs zero immediately; the next start gives the correct product.
REQ-031 SHALL cover: randomized 1000 pairs at WIDTH=8 and WIDTH=5, each compared to the $signed reference product.
